// File: rtl/stepper_pkg.sv
// Shared definitions for the elevator stepper move sequencer: coil patterns,
// FSM encoding and the default step rate.
package stepper_pkg;

  localparam int unsigned DefaultClkDiv = 50000;

  // Coil patterns ordered {x, y, xb, yb}
  localparam logic [3:0] P0 = 4'b0011;
  localparam logic [3:0] P1 = 4'b1001;
  localparam logic [3:0] P2 = 4'b1100;
  localparam logic [3:0] P3 = 4'b0110;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic [3:0] phase_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0:    pat = P0;
      2'd1:    pat = P1;
      2'd2:    pat = P2;
      default: pat = P3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running 0..CLK_DIV-1 step-rate counter with synchronous clear and enable;
// tick is high for the one cycle in which the counter sits at its terminal count.
module step_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move sequencer: accepts a (dir, steps) command, paces the full-step coil
// sequence at one step per CLK_DIV cycles, tracks absolute position and pulses done.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DefaultClkDiv,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned POS_W     = 16,
  parameter bit          HOLD_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              x,
  output logic              y,
  output logic              xb,
  output logic              yb,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  localparam logic [3:0] CoilRst = HOLD_IDLE ? P0 : 4'b0000;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        phase_q, phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [3:0]        coil_q, coil_d;
  logic              accept;
  logic              tick;

  assign accept = cmd_valid && (state_q == StIdle);

  step_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q == StRun),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          rem_d   = cmd_steps;
          state_d = (cmd_steps == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Abort beats a coincident tick: the move stops without taking that step.
        if (abort) begin
          state_d = StDone;
        end else if (tick) begin
          phase_d = dir_q ? phase_q - 2'd1 : phase_q + 2'd1;
          pos_d   = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
          rem_d   = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    coil_d = (HOLD_IDLE || (state_d == StRun)) ? phase_pattern(phase_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      phase_q <= 2'd0;
      pos_q   <= '0;
      coil_q  <= CoilRst;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      coil_q  <= coil_d;
    end
  end

  assign {x, y, xb, yb} = coil_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign cmd_ready = (state_q == StIdle);
  assign position  = pos_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed self-checking bench for stepper_move_ctrl with CLK_DIV=4, HOLD_IDLE=1.
module tb_stepper_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        abort = 1'b0;
  logic        x, y, xb, yb;
  logic        busy, done;
  logic [15:0] position;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] coils;
  assign coils = {x, y, xb, yb};

  stepper_move_ctrl #(
    .CLK_DIV   (4),
    .STEP_W    (16),
    .POS_W     (16),
    .HOLD_IDLE (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .x         (x),
    .y         (y),
    .xb        (xb),
    .yb        (yb),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then land on the following falling edge for sampling.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command at a falling edge; it is accepted on the next rising edge.
  task automatic send(input logic dir, input logic [15:0] steps);
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] fwd_seq [5];
  logic [3:0] rev_seq [3];

  initial begin
    fwd_seq = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001};
    rev_seq = '{4'b0011, 4'b0110, 4'b1100};

    // Reset state
    edges(2);
    rst = 1'b0;
    check("rst_coils", 32'(coils), 32'h3);
    check("rst_pos", 32'(position), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);

    // 1: reset asserted mid-RUN
    send(1'b0, 16'd5);
    edges(5);
    check("t1_pre_pos", 32'(position), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_coils", 32'(coils), 32'h3);
    check("t1_pos", 32'(position), 32'h0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_ready", 32'(cmd_ready), 32'd1);
    edges(1);
    rst = 1'b0;
    check("t1_done", 32'(done), 32'd0);
    edges(1);
    check("t1_done_after", 32'(done), 32'd0);
    check("t1_ready_after", 32'(cmd_ready), 32'd1);

    // 2: forward 5 steps
    send(1'b0, 16'd5);
    check("t2_busy0", 32'(busy), 32'd1);
    check("t2_coils0", 32'(coils), 32'h3);
    for (int k = 0; k < 5; k++) begin
      edges(3);
      check("t2_hold", 32'(coils), 32'((k == 0) ? 4'b0011 : fwd_seq[k-1]));
      check("t2_busy", 32'(busy), 32'd1);
      edges(1);
      check("t2_step", 32'(coils), 32'(fwd_seq[k]));
      check("t2_pos", 32'(position), 32'(k + 1));
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    edges(1);
    check("t2_done_clr", 32'(done), 32'd0);

    // 3: reverse 3 steps
    send(1'b1, 16'd3);
    for (int k = 0; k < 3; k++) begin
      edges(4);
      check("t3_step", 32'(coils), 32'(rev_seq[k]));
    end
    check("t3_pos", 32'(position), 32'd2);
    check("t3_done", 32'(done), 32'd1);
    edges(1);
    check("t3_done_clr", 32'(done), 32'd0);

    // 4: zero-length move
    send(1'b0, 16'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_coils", 32'(coils), 32'hC);
    check("t4_pos", 32'(position), 32'd2);
    edges(1);
    check("t4_done_clr", 32'(done), 32'd0);
    check("t4_ready", 32'(cmd_ready), 32'd1);

    // 5a: abort coincident with the 3rd tick
    send(1'b0, 16'd10);
    edges(4);
    check("t5a_step1", 32'(coils), 32'h6);
    edges(4);
    check("t5a_step2", 32'(coils), 32'h3);
    edges(3);
    abort = 1'b1;
    edges(1);
    abort = 1'b0;
    check("t5a_done", 32'(done), 32'd1);
    check("t5a_pos", 32'(position), 32'd4);
    check("t5a_coils", 32'(coils), 32'h3);
    edges(1);
    check("t5a_done_clr", 32'(done), 32'd0);
    edges(4);
    check("t5a_frozen", 32'(coils), 32'h3);
    check("t5a_pos_frozen", 32'(position), 32'd4);

    // 5b: abort between ticks
    send(1'b0, 16'd10);
    edges(8);
    check("t5b_step2", 32'(coils), 32'hC);
    edges(1);
    abort = 1'b1;
    edges(1);
    abort = 1'b0;
    check("t5b_done", 32'(done), 32'd1);
    edges(4);
    check("t5b_coils", 32'(coils), 32'hC);
    check("t5b_pos", 32'(position), 32'd6);
    check("t5b_ready", 32'(cmd_ready), 32'd1);

    // 6: wrap below zero, cmd_valid held through the move
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 16'd1;
    edges(1);
    check("t6_busy", 32'(busy), 32'd1);
    edges(3);
    check("t6_ready_run", 32'(cmd_ready), 32'd0);
    edges(1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_pos", 32'(position), 32'hFFFF);
    check("t6_coils", 32'(coils), 32'h6);
    check("t6_ready_done", 32'(cmd_ready), 32'd0);
    edges(1);
    check("t6_ready_idle", 32'(cmd_ready), 32'd1);
    check("t6_busy_idle", 32'(busy), 32'd0);
    edges(1);
    cmd_valid = 1'b0;
    check("t6_second_accept", 32'(busy), 32'd1);
    edges(4);
    check("t6_second_done", 32'(done), 32'd1);
    check("t6_second_pos", 32'(position), 32'hFFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
